// File: rtl/msp430_pkg.sv
// msp430_pkg: shared prefetch state encodings and default geometry.
package msp430_pkg;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} pf_state_t;
  localparam int PF_DEPTH = 4;
  localparam int PF_AW = 16;
  localparam int PF_DW = 16;
  localparam int WORD_BYTES = 2;
endpackage

// File: rtl/pf_fifo.sv
// pf_fifo: DEPTH-entry synchronous FIFO with clear; clear has priority over push/pop.
module pf_fifo
  import msp430_pkg::*;
#(
  parameter int DEPTH = PF_DEPTH,
  parameter int W = PF_AW + PF_DW
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_clr,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic [W-1:0]           i_din,
  output logic [W-1:0]           o_dout,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int PW = $clog2(DEPTH);
  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr, r_rd;
  logic [PW:0]   r_cnt;
  logic          w_pop;
  assign w_pop = i_pop && r_cnt != '0;
  assign o_dout = r_mem[r_rd];
  assign o_count = r_cnt;
  always_ff @(posedge clk)
    if (i_push) r_mem[r_wr] <= i_din;
  always_ff @(posedge clk) begin
    if (!rst || i_clr) begin
      r_wr <= '0;
      r_rd <= '0;
      r_cnt <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd + 1'b1;
      r_cnt <= r_cnt + (PW+1)'(i_push) - (PW+1)'(w_pop);
    end
  end
endmodule

// File: rtl/instr_prefetch.sv
// instr_prefetch: sequential instruction prefetch queue with flush redirect.
// Optional PREFETCH_PERF_EN adds saturating perf_fetch/perf_starve counters.
module instr_prefetch
  import msp430_pkg::*;
#(
  parameter int DEPTH = PF_DEPTH,
  parameter int AW = PF_AW,
  parameter int DW = PF_DW
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [AW-1:0]          RST_VEC,
  input  logic                   flush,
  input  logic [AW-1:0]          flush_pc,
  output logic                   mem_req,
  output logic [AW-1:0]          mem_addr,
  input  logic                   mem_ack,
  input  logic [DW-1:0]          mem_data,
  output logic                   ins_valid,
  output logic [DW-1:0]          ins_word,
  output logic [AW-1:0]          ins_addr,
  input  logic                   ins_ready,
  output logic [$clog2(DEPTH):0] q_count
`ifdef PREFETCH_PERF_EN
  ,
  output logic [15:0]            perf_fetch,
  output logic [15:0]            perf_starve
`endif
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [AW-1:0] ALIGN = ~AW'(1);
  pf_state_t        r_state, w_state_nx;
  logic [AW-1:0]    r_fetch, r_addr, w_fetch_nx, w_addr_nx;
  logic [AW+DW-1:0] w_head;
  logic [CW-1:0]    w_count;
  logic             w_push, w_pop, w_space;
  assign w_push = r_state == S_WAIT && mem_ack && !flush;
  assign w_pop = ins_valid && ins_ready;
  assign w_space = (w_pop ? w_count : w_count + 1'b1) < FULL;
  assign mem_req = r_state != S_IDLE;
  assign mem_addr = r_addr;
  assign ins_valid = w_count != '0;
  assign {ins_addr, ins_word} = ins_valid ? w_head : '0;
  assign q_count = w_count;
  pf_fifo #(.DEPTH(DEPTH), .W(AW+DW)) u_fifo (
    .clk(clk), .rst(rst), .i_clr(flush), .i_push(w_push), .i_pop(w_pop),
    .i_din({r_fetch, mem_data}), .o_dout(w_head), .o_count(w_count)
  );
  // A live request is never cancelled: a flush without ack parks in S_DROP.
  always_comb begin
    w_state_nx = r_state;
    w_fetch_nx = r_fetch;
    w_addr_nx = r_addr;
    if (flush) begin
      w_fetch_nx = flush_pc & ALIGN;
      w_state_nx = (r_state != S_IDLE && !mem_ack) ? S_DROP : S_IDLE;
      w_addr_nx = w_state_nx == S_IDLE ? w_fetch_nx : r_addr;
    end else if (r_state == S_IDLE) begin
      w_state_nx = w_count < FULL ? S_WAIT : S_IDLE;
      w_addr_nx = r_fetch;
    end else if (mem_ack && r_state == S_DROP) begin
      w_state_nx = S_IDLE;
    end else if (mem_ack) begin
      w_fetch_nx = r_fetch + AW'(WORD_BYTES);
      w_addr_nx = w_fetch_nx;
      w_state_nx = w_space ? S_WAIT : S_IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_fetch <= RST_VEC & ALIGN;
      r_addr <= RST_VEC & ALIGN;
    end else begin
      r_state <= w_state_nx;
      r_fetch <= w_fetch_nx;
      r_addr <= w_addr_nx;
    end
  end
`ifdef PREFETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_fetch <= '0;
      perf_starve <= '0;
    end else begin
      if (w_push && perf_fetch != 16'hFFFF) perf_fetch <= perf_fetch + 1'b1;
      if (ins_ready && !ins_valid && perf_starve != 16'hFFFF) perf_starve <= perf_starve + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_instr_prefetch.sv
// tb_instr_prefetch: vector table, directed flush/wrap/reset sequences, randomized run vs queue model.
module tb_instr_prefetch;
  localparam int DEPTH = 4;
  logic        clk = 0, rst = 0, flush = 0, mem_ack = 0, ins_ready = 0;
  logic [15:0] rst_vec = 16'hC000, flush_pc = 0, mem_data = 0;
  logic        mem_req, ins_valid;
  logic [15:0] mem_addr, ins_word, ins_addr;
  logic [2:0]  q_count;
`ifdef PREFETCH_PERF_EN
  logic [15:0] perf_fetch, perf_starve;
`endif
  int total = 0, bad = 0;

  instr_prefetch dut (
    .clk(clk), .rst(rst), .RST_VEC(rst_vec), .flush(flush), .flush_pc(flush_pc),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
    .ins_valid(ins_valid), .ins_word(ins_word), .ins_addr(ins_addr),
    .ins_ready(ins_ready), .q_count(q_count)
`ifdef PREFETCH_PERF_EN
    , .perf_fetch(perf_fetch), .perf_starve(perf_starve)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: timeout reached, required finish");
    $fatal(1);
  end

  function automatic logic [15:0] img(input logic [15:0] a);
    return (a * 16'd13) ^ 16'h5A3C;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic ack, rdy, req;
    logic [15:0] addr;
    logic vld;
    logic [15:0] ia;
    logic [2:0] cnt;
  } vec_t;
  vec_t tbl[13];

  typedef struct {logic [15:0] a; logic [15:0] w;} ent_t;
  ent_t q[$];

  initial begin
    logic [15:0] exp_ptr, a_addr, prev_addr;
    logic stale, a_req, pop, prev_live, prev_req;
    int wcnt, lat;
    // {ack, ready | req, mem_addr, valid, ins_addr, count}: check, then drive
    tbl[0]  = '{0, 0, 0, 16'h0000, 0, 16'h0000, 3'd0};
    tbl[1]  = '{1, 0, 1, 16'hC000, 0, 16'h0000, 3'd0};
    tbl[2]  = '{1, 0, 1, 16'hC002, 1, 16'hC000, 3'd1};
    tbl[3]  = '{1, 0, 1, 16'hC004, 1, 16'hC000, 3'd2};
    tbl[4]  = '{1, 0, 1, 16'hC006, 1, 16'hC000, 3'd3};
    tbl[5]  = '{0, 0, 0, 16'h0000, 1, 16'hC000, 3'd4};
    tbl[6]  = '{0, 1, 0, 16'h0000, 1, 16'hC000, 3'd4};
    tbl[7]  = '{0, 0, 0, 16'h0000, 1, 16'hC002, 3'd3};
    tbl[8]  = '{0, 0, 1, 16'hC008, 1, 16'hC002, 3'd3};
    tbl[9]  = '{1, 0, 1, 16'hC008, 1, 16'hC002, 3'd3};
    tbl[10] = '{0, 1, 0, 16'h0000, 1, 16'hC002, 3'd4};
    tbl[11] = '{0, 1, 0, 16'h0000, 1, 16'hC004, 3'd3};
    tbl[12] = '{0, 0, 1, 16'hC00A, 1, 16'hC006, 3'd2};
    step();
    step();
    rst = 1;
    for (int i = 0; i < 13; i++) begin
      chk($sformatf("t%0d_req", i), mem_req, tbl[i].req);
      if (tbl[i].req) chk($sformatf("t%0d_addr", i), mem_addr, tbl[i].addr);
      chk($sformatf("t%0d_vld", i), ins_valid, tbl[i].vld);
      chk($sformatf("t%0d_iaddr", i), ins_addr, tbl[i].ia);
      chk($sformatf("t%0d_word", i), ins_word, tbl[i].vld ? img(tbl[i].ia) : 16'h0);
      chk($sformatf("t%0d_cnt", i), q_count, tbl[i].cnt);
      mem_ack = tbl[i].ack;
      mem_data = img(mem_addr);
      ins_ready = tbl[i].rdy;
      step();
    end
    mem_ack = 0;
    ins_ready = 0;
    // flush with a live request; its late ack carries poison data
    flush = 1; flush_pc = 16'hD011; step(); flush = 0;
    chk("drop_cnt", q_count, 0);
    chk("drop_req", mem_req, 1);
    chk("drop_addr", mem_addr, 16'hC00A);
    step(); step();
    mem_ack = 1; mem_data = 16'hDEAD; step(); mem_ack = 0;
    chk("drop_discard_cnt", q_count, 0);
    chk("drop_discard_req", mem_req, 0);
    step();
    chk("redir_req", mem_req, 1);
    chk("redir_addr", mem_addr, 16'hD010);
    mem_ack = 1; mem_data = img(mem_addr); step(); mem_ack = 0;
    chk("redir_iaddr", ins_addr, 16'hD010);
    chk("redir_word", ins_word, img(16'hD010));
    chk("redir_cnt", q_count, 1);
    // flush coinciding with ack and pop
    mem_ack = 1; mem_data = img(mem_addr); ins_ready = 1; flush = 1; flush_pc = 16'hE000;
    step();
    mem_ack = 0; ins_ready = 0; flush = 0;
    chk("fack_cnt", q_count, 0);
    chk("fack_vld", ins_valid, 0);
    chk("fack_addr", mem_addr, 16'hE000);
    step();
    chk("fack_req", mem_req, 1);
    // address wrap at top of space
    mem_ack = 1; flush = 1; flush_pc = 16'hFFFE; step(); mem_ack = 0; flush = 0;
    chk("wrap_idle", mem_req, 0);
    step();
    chk("wrap_a0", mem_addr, 16'hFFFE);
    mem_ack = 1; mem_data = img(mem_addr); step();
    chk("wrap_a1", mem_addr, 16'h0000);
    mem_data = img(mem_addr); step(); mem_ack = 0;
    chk("wrap_i0", ins_addr, 16'hFFFE);
    chk("wrap_cnt", q_count, 2);
    ins_ready = 1; step(); ins_ready = 0;
    chk("wrap_i1", ins_addr, 16'h0000);
    chk("wrap_w1", ins_word, img(16'h0000));
    // reset while a request is live, then a stray late ack
    rst = 0; step(); rst = 1;
    chk("rstmid_req", mem_req, 0);
    chk("rstmid_cnt", q_count, 0);
    mem_ack = 1; mem_data = 16'hBEEF; step(); mem_ack = 0;
    chk("late_ack_cnt", q_count, 0);
    chk("late_ack_addr", mem_addr, 16'hC000);
    // randomized run against a queue model
    rst = 0; step(); rst = 1;
    q.delete(); exp_ptr = rst_vec; stale = 0;
    wcnt = 0; lat = 0; prev_live = 0; prev_req = 0; prev_addr = 0;
    for (int i = 0; i < 3000; i++) begin
      chk("rnd_vld", ins_valid, q.size() != 0);
      chk("rnd_cnt", q_count, q.size());
      chk("rnd_iaddr", ins_addr, q.size() != 0 ? q[0].a : 16'h0);
      chk("rnd_word", ins_word, q.size() != 0 ? q[0].w : 16'h0);
      if (mem_req && !prev_req) chk("rnd_room", q.size() < DEPTH, 1);
      if (prev_live) begin
        chk("rnd_hold_req", mem_req, 1);
        chk("rnd_hold_addr", mem_addr, prev_addr);
      end
      ins_ready = $urandom_range(0, 99) < (((i / 250) % 2) != 0 ? 90 : 25);
      flush = $urandom_range(0, 24) == 0;
      flush_pc = 16'($urandom);
      if (!mem_req) wcnt = 0;
      mem_ack = mem_req && wcnt >= lat;
      mem_data = mem_ack ? img(mem_addr) : 16'($urandom);
      if (mem_ack) begin
        wcnt = 0;
        lat = $urandom_range(0, 3);
      end else if (mem_req) wcnt++;
      a_req = mem_req; a_addr = mem_addr; pop = ins_ready && q.size() != 0;
      prev_req = mem_req; prev_live = mem_req && !mem_ack; prev_addr = mem_addr;
      step();
      if (flush) begin
        q.delete();
        exp_ptr = flush_pc & 16'hFFFE;
        stale = a_req && !mem_ack;
      end else begin
        if (pop) void'(q.pop_front());
        if (mem_ack && stale) stale = 0;
        else if (mem_ack) begin
          chk("rnd_fetch_addr", a_addr, exp_ptr);
          q.push_back('{exp_ptr, img(exp_ptr)});
          exp_ptr += 16'd2;
        end
      end
    end
    mem_ack = 0; flush = 0; ins_ready = 0;
`ifdef PREFETCH_PERF_EN
    begin
      int n;
      rst = 0; step(); rst = 1;
      chk("perf_rst_fetch", perf_fetch, 0);
      chk("perf_rst_starve", perf_starve, 0);
      ins_ready = 1;
      repeat (5) step();
      n = 0;
      for (int k = 0; k < 200 && n < 10; k++) begin
        mem_ack = mem_req;
        mem_data = img(mem_addr);
        ins_ready = ins_valid;
        if (mem_ack) n++;
        step();
      end
      mem_ack = 0; ins_ready = 0;
      chk("perf_fetch", perf_fetch, 10);
      chk("perf_starve", perf_starve, 5);
      for (int k = 0; k < 10 && !mem_req; k++) step();
      rst = 0; step(); rst = 1;
      chk("perf_clr_fetch", perf_fetch, 0);
      chk("perf_clr_starve", perf_starve, 0);
      chk("perf_clr_req", mem_req, 0);
    end
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
